data_mem_controller: RTL and testbench

- Sits downstream of the compute cores.
- Arbitrates the per-thread data-memory read/write requests of all cores (NUM_CONSUMERS = cores × THREADS_PER_BLOCK) onto NUM_CHANNELS external data-memory channels.
- Each channel runs an independent FSM that claims one pending consumer, forwards the request to memory, then relays the completion back with a valid/ready handshake.

---
 rtl/data_mem_controller.sv | 158 +++++++++++++++
 tb/tb_data_mem_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// data_mem_controller: arbitrates per-thread data-memory requests onto NUM_CHANNELS memory channels.
// Define DATA_MEM_CTRL_RR_EN for a per-channel round-robin scan; otherwise fixed lowest-index priority.
module data_mem_controller #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] StIdle          = 3'd0;
  localparam logic [2:0] StReadWaiting   = 3'd1;
  localparam logic [2:0] StWriteWaiting  = 3'd2;
  localparam logic [2:0] StReadRelaying  = 3'd3;
  localparam logic [2:0] StWriteRelaying = 3'd4;

  logic [NUM_CHANNELS-1:0][2:0]      state;
  logic [NUM_CHANNELS-1:0][IdxW-1:0] cur_idx;
  logic [NUM_CONSUMERS-1:0]          claimed;
  logic [NUM_CONSUMERS-1:0]          taken;
  logic [NUM_CHANNELS-1:0]           grant_valid;
  logic [NUM_CHANNELS-1:0]           grant_read;
  logic [NUM_CHANNELS-1:0][IdxW-1:0] grant_idx;
`ifdef DATA_MEM_CTRL_RR_EN
  logic [NUM_CHANNELS-1:0][IdxW-1:0] last_grant;
`endif

  // Channels claim in ascending order; 'taken' hides consumers grabbed by lower channels this cycle.
  always_comb begin
    int unsigned start;
    int unsigned cand;
    logic [IdxW-1:0] cidx;
    taken       = claimed;
    grant_valid = '0;
    grant_read  = '0;
    grant_idx   = '0;
    start       = 0;
    cand        = 0;
    cidx        = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
`ifdef DATA_MEM_CTRL_RR_EN
      start = 32'(last_grant[ch]) + 1;
      if (start >= NUM_CONSUMERS) start = 0;
`else
      start = 0;
`endif
      if (state[ch] == StIdle) begin
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
          cand = start + k;
          if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
          cidx = IdxW'(cand);
          if (!grant_valid[ch] && !taken[cidx] &&
              (consumer_read_valid[cidx] || consumer_write_valid[cidx])) begin
            grant_valid[ch] = 1'b1;
            grant_idx[ch]   = cidx;
            grant_read[ch]  = consumer_read_valid[cidx];
          end
        end
      end
      if (grant_valid[ch]) taken[grant_idx[ch]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= '0;
      cur_idx              <= '0;
      claimed              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
`ifdef DATA_MEM_CTRL_RR_EN
      last_grant           <= {NUM_CHANNELS{IdxW'(NUM_CONSUMERS - 1)}};
`endif
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state[ch])
          StIdle: begin
            if (grant_valid[ch]) begin
              cur_idx[ch]            <= grant_idx[ch];
              claimed[grant_idx[ch]] <= 1'b1;
`ifdef DATA_MEM_CTRL_RR_EN
              last_grant[ch]         <= grant_idx[ch];
`endif
              // Read wins when a consumer raises both; its write is picked up later.
              if (grant_read[ch]) begin
                mem_read_valid[ch]   <= 1'b1;
                mem_read_address[ch] <= consumer_read_address[grant_idx[ch]];
                state[ch]            <= StReadWaiting;
              end else begin
                mem_write_valid[ch]   <= 1'b1;
                mem_write_address[ch] <= consumer_write_address[grant_idx[ch]];
                mem_write_data[ch]    <= consumer_write_data[grant_idx[ch]];
                state[ch]             <= StWriteWaiting;
              end
            end
          end
          StReadWaiting: begin
            if (mem_read_ready[ch]) begin
              mem_read_valid[ch]                  <= 1'b0;
              consumer_read_data[cur_idx[ch]]     <= mem_read_data[ch];
              consumer_read_ready[cur_idx[ch]]    <= 1'b1;
              state[ch]                           <= StReadRelaying;
            end
          end
          StWriteWaiting: begin
            if (mem_write_ready[ch]) begin
              mem_write_valid[ch]                 <= 1'b0;
              consumer_write_ready[cur_idx[ch]]   <= 1'b1;
              state[ch]                           <= StWriteRelaying;
            end
          end
          StReadRelaying: begin
            if (!consumer_read_valid[cur_idx[ch]]) begin
              consumer_read_ready[cur_idx[ch]] <= 1'b0;
              claimed[cur_idx[ch]]             <= 1'b0;
              state[ch]                        <= StIdle;
            end
          end
          StWriteRelaying: begin
            if (!consumer_write_valid[cur_idx[ch]]) begin
              consumer_write_ready[cur_idx[ch]] <= 1'b0;
              claimed[cur_idx[ch]]              <= 1'b0;
              state[ch]                         <= StIdle;
            end
          end
          default: state[ch] <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: directed steps, scoreboard queue, memory responders.
module tb_data_mem_controller;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NC = 8;
  localparam int NCH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [NC-1:0]          c_rv, c_rr, c_wv, c_wr;
  logic [NC-1:0][AW-1:0]  c_ra, c_wa;
  logic [NC-1:0][DW-1:0]  c_rd, c_wd;
  logic [NCH-1:0]         m_rv, m_rr, m_wv, m_wr;
  logic [NCH-1:0][AW-1:0] m_ra, m_wa;
  logic [NCH-1:0][DW-1:0] m_rd, m_wd;

  // Single-channel instance for the grant-order check.
  logic [NC-1:0]         f_rv, f_rr, f_wv, f_wr;
  logic [NC-1:0][AW-1:0] f_ra, f_wa;
  logic [NC-1:0][DW-1:0] f_rd, f_wd;
  logic [0:0]            fm_rv, fm_rr, fm_wv, fm_wr;
  logic [0:0][AW-1:0]    fm_ra, fm_wa;
  logic [0:0][DW-1:0]    fm_rd, fm_wd;

  data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) u_dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
    .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
    .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
    .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
    .mem_read_valid(m_rv), .mem_read_address(m_ra),
    .mem_read_ready(m_rr), .mem_read_data(m_rd),
    .mem_write_valid(m_wv), .mem_write_address(m_wa),
    .mem_write_data(m_wd), .mem_write_ready(m_wr)
  );

  data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(f_rv), .consumer_read_address(f_ra),
    .consumer_read_ready(f_rr), .consumer_read_data(f_rd),
    .consumer_write_valid(f_wv), .consumer_write_address(f_wa),
    .consumer_write_data(f_wd), .consumer_write_ready(f_wr),
    .mem_read_valid(fm_rv), .mem_read_address(fm_ra),
    .mem_read_ready(fm_rr), .mem_read_data(fm_rd),
    .mem_write_valid(fm_wv), .mem_write_address(fm_wa),
    .mem_write_data(fm_wd), .mem_write_ready(fm_wr)
  );

  typedef struct {
    int          cons;
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  data;
  } sb_t;

  sb_t        sb[$];
  int         grants[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         lat = 0;
  int         rcnt[NCH];
  int         wcnt[NCH];
  int         rise_r[NC];
  int         rise_w[NC];
  logic [7:0] mem_model[256];
  logic [7:0] wmem[256];
  logic [NC-1:0] prev_rr = '0, prev_wr = '0, f_prev = '0, f_re = '0;
  bit         fair_on = 1'b0;

  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s observed=mismatch expected=match", tag);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory for the two-channel instance; ready is a one-cycle pulse after 'lat' idle cycles.
  always @(negedge clk) begin
    for (int g = 0; g < NCH; g++) begin
      if (m_rr[g]) m_rr[g] = 1'b0;
      else if (m_rv[g]) begin
        if (rcnt[g] >= lat) begin
          m_rr[g] = 1'b1; m_rd[g] = mem_model[m_ra[g]]; rcnt[g] = 0;
        end else rcnt[g]++;
      end else rcnt[g] = 0;
      if (m_wr[g]) m_wr[g] = 1'b0;
      else if (m_wv[g]) begin
        if (wcnt[g] >= lat) begin
          m_wr[g] = 1'b1; wmem[m_wa[g]] = m_wd[g]; wcnt[g] = 0;
        end else wcnt[g]++;
      end else wcnt[g] = 0;
    end
  end

  // Zero-wait memory for the single-channel instance.
  always @(negedge clk) begin
    if (fm_rr[0]) fm_rr[0] = 1'b0;
    else if (fm_rv[0]) begin fm_rr[0] = 1'b1; fm_rd[0] = mem_model[fm_ra[0]]; end
  end

  // Completion monitor: pops the matching scoreboard entry, then the consumer drops valid.
  always @(negedge clk) begin : mon
    int found;
    for (int c = 0; c < NC; c++) begin
      if (c_rr[c] && !prev_rr[c]) begin
        rise_r[c] = cyc;
        found = -1;
        foreach (sb[i]) if (found < 0 && sb[i].cons == c && !sb[i].wr) found = i;
        chk("rd_expected", found >= 0);
        if (found >= 0) begin
          chk("rd_data", c_rd[c] === sb[found].data);
          sb.delete(found);
        end
        c_rv[c] = 1'b0;
      end
      if (c_wr[c] && !prev_wr[c]) begin
        rise_w[c] = cyc;
        found = -1;
        foreach (sb[i]) if (found < 0 && sb[i].cons == c && sb[i].wr) found = i;
        chk("wr_expected", found >= 0);
        if (found >= 0) begin
          chk("wr_mem_data", wmem[sb[found].addr] === sb[found].data);
          sb.delete(found);
        end
        c_wv[c] = 1'b0;
      end
    end
    prev_rr = c_rr;
    prev_wr = c_wr;
  end

  // Grant recorder for the single-channel instance; consumers 0/1 re-request after each grant.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (f_rr[c] && !f_prev[c]) begin
        if (fair_on) grants.push_back(c);
        f_rv[c] = 1'b0;
        f_re[c] = 1'b1;
      end else if (f_re[c]) begin
        f_re[c] = 1'b0;
        if (fair_on) f_rv[c] = 1'b1;
      end
    end
    f_prev = f_rr;
  end

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size() == 0);
  endtask

  task automatic push_rd(input int c, input logic [7:0] a, input logic [7:0] d);
    mem_model[a] = d;
    c_ra[c] = a;
    c_rv[c] = 1'b1;
    sb.push_back('{cons: c, wr: 1'b0, addr: a, data: d});
  endtask

  initial begin
    int exp_g[4];
    int n;
    reset = 1'b0;
    c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
    f_rv = '0; f_wv = '0; f_ra = '0; f_wa = '0; f_wd = '0;
    m_rr = '0; m_wr = '0; m_rd = '0; fm_rr = '0; fm_wr = '0; fm_rd = '0;
    for (int i = 0; i < 256; i++) begin mem_model[i] = 8'(i) ^ 8'h5A; wmem[i] = 8'h00; end
    for (int i = 0; i < NCH; i++) begin rcnt[i] = 0; wcnt[i] = 0; end
    for (int i = 0; i < NC; i++) begin rise_r[i] = 0; rise_w[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_mem_rv", m_rv === '0);
    chk("rst_mem_wv", m_wv === '0);
    chk("rst_c_rr", c_rr === '0);
    chk("rst_c_wr", c_wr === '0);
    chk("rst_mem_ra", m_ra === '0);
    chk("rst_c_rd", c_rd === '0);
    reset = 1'b1;
    @(negedge clk);

    // Single read, two wait cycles
    lat = 2;
    push_rd(3, 8'h10, 8'hAB);
    @(negedge clk);
    chk("rd_mem_rv", m_rv === 2'b01);
    chk("rd_mem_ra", m_ra[0] === 8'h10);
    chk("rd_no_write", m_wv === '0);
    wait_drain("rd_done", 20);
    repeat (2) @(negedge clk);
    chk("rd_ready_clear", c_rr === '0);
    chk("rd_mem_idle", m_rv === '0);
    chk("rd_data_hold", c_rd[3] === 8'hAB);

    // Single write
    lat = 1;
    c_wa[5] = 8'h20; c_wd[5] = 8'h7E; c_wv[5] = 1'b1;
    sb.push_back('{cons: 5, wr: 1'b1, addr: 8'h20, data: 8'h7E});
    @(negedge clk);
    chk("wr_mem_wv", m_wv === 2'b01);
    chk("wr_mem_wa", m_wa[0] === 8'h20);
    chk("wr_mem_wd", m_wd[0] === 8'h7E);
    chk("wr_no_read", m_rv === '0);
    wait_drain("wr_done", 20);
    repeat (2) @(negedge clk);
    chk("wr_ready_clear", c_wr === '0);

    // Contention: three readers, two channels
    lat = 1;
    push_rd(0, 8'h30, 8'hC0);
    push_rd(1, 8'h31, 8'hC1);
    push_rd(2, 8'h32, 8'hC2);
    @(negedge clk);
    chk("cont_mem_rv", m_rv === 2'b11);
    chk("cont_ch0_addr", m_ra[0] === 8'h30);
    chk("cont_ch1_addr", m_ra[1] === 8'h31);
    wait_drain("cont_done", 40);
    chk("cont_c2_later", rise_r[2] > rise_r[0]);
    repeat (2) @(negedge clk);

    // Simultaneous completion on both channels
    lat = 0;
    push_rd(4, 8'h40, 8'h11);
    push_rd(6, 8'h41, 8'h22);
    wait_drain("simul_done", 20);
    chk("simul_same_cycle", rise_r[4] == rise_r[6]);
    repeat (2) @(negedge clk);

    // Read and write raised together: read first, write stays pending
    lat = 1;
    c_wa[2] = 8'h61; c_wd[2] = 8'h33; c_wv[2] = 1'b1;
    sb.push_back('{cons: 2, wr: 1'b1, addr: 8'h61, data: 8'h33});
    push_rd(2, 8'h60, 8'h9C);
    @(negedge clk);
    chk("rw_read_first", m_rv === 2'b01);
    chk("rw_no_write", m_wv === '0);
    wait_drain("rw_done", 40);
    chk("rw_order", rise_w[2] > rise_r[2]);
    repeat (2) @(negedge clk);

    // Reset during READ_WAITING
    lat = 10;
    c_ra[7] = 8'h50; c_rv[7] = 1'b1;
    @(negedge clk);
    chk("mid_mem_rv", m_rv === 2'b01);
    @(negedge clk);
    reset = 1'b0;
    c_rv[7] = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_rv", m_rv === '0);
    chk("mid_rst_c_rr", c_rr === '0);
    reset = 1'b1;
    lat = 0;
    push_rd(7, 8'h51, 8'h5A);
    @(negedge clk);
    chk("mid_fresh_addr", m_ra[0] === 8'h51);
    chk("mid_fresh_rv", m_rv === 2'b01);
    wait_drain("mid_fresh_done", 20);

    // Grant order with one channel and two continuous requesters
    f_ra[0] = 8'h70; f_ra[1] = 8'h71;
    fair_on = 1'b1;
    f_rv[0] = 1'b1; f_rv[1] = 1'b1;
    n = 0;
    while (grants.size() < 4 && n < 80) begin @(negedge clk); n++; end
    fair_on = 1'b0;
    f_rv = '0;
    chk("fair_count", grants.size() >= 4);
`ifdef DATA_MEM_CTRL_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("fair_grant", grants[i] == exp_g[i]);
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
